// File: rtl/fabint_collector_if.sv
// APB3 slave bus bundle for fabint_collector.
// Master drives request fields; the slave returns read data, ready and error.
interface fabint_collector_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fabint_collector.sv
// Collects fabric interrupt edges into sticky pending bits, drives a level irq to the MSS,
// and exposes status/clear/enable/raw/overrun registers over APB3.
module fabint_collector #(
    parameter int NSRC  = 4,
    parameter int OVR_W = 8
) (
    input  logic                pclk,
    input  logic                nreset,
    input  logic [NSRC-1:0]     irq_in,
    fabint_collector_if.slave   apb,
    output logic                fabint
);

    localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};

    logic [NSRC-1:0]  r_irq_d;
    logic [NSRC-1:0]  r_pending;
    logic [NSRC-1:0]  r_enable;
    logic [OVR_W-1:0] r_ovr [NSRC];
    logic             r_fabint;

    logic [NSRC-1:0]  w_edge;
    logic [NSRC-1:0]  w_clr;
    logic [NSRC-1:0]  w_pending_next;
    logic [NSRC-1:0]  w_enable_next;
    logic             w_acc;
    logic             w_wr;
    logic             w_rd;
    logic [5:0]       w_word;
    logic             w_is_ovr;
    logic [3:0]       w_ovr_idx;
    logic             w_valid;
    logic             w_unused;

    assign w_acc     = apb.psel & apb.penable;
    assign w_wr      = w_acc & apb.pwrite;
    assign w_rd      = w_acc & ~apb.pwrite;
    assign w_word    = apb.paddr[7:2];
    assign w_is_ovr  = (w_word >= 6'd4) && (w_word < 6'(4 + NSRC));
    assign w_ovr_idx = 4'(w_word - 6'd4);
    assign w_valid   = (w_word < 6'd4) || w_is_ovr;

    assign w_edge         = irq_in & ~r_irq_d;
    assign w_clr          = (w_wr && w_word == 6'd1) ? apb.pwdata[NSRC-1:0] : '0;
    // A fresh edge wins over a same-cycle clear so no event is lost.
    assign w_pending_next = w_edge | (r_pending & ~w_clr);
    assign w_enable_next  = (w_wr && w_word == 6'd2) ? apb.pwdata[NSRC-1:0] : r_enable;

    assign apb.pready  = 1'b1;
    assign apb.pslverr = w_acc & ~w_valid;
    assign fabint      = r_fabint;
    assign w_unused    = ^{apb.paddr[1:0], apb.pwdata};

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        apb.prdata = '0;
        if (w_rd && w_valid) begin
            case (w_word)
                6'd0: apb.prdata[NSRC-1:0] = r_pending;
                6'd2: apb.prdata[NSRC-1:0] = r_enable;
                6'd3: apb.prdata[NSRC-1:0] = r_irq_d;
                default: begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (w_is_ovr && w_ovr_idx == 4'(i))
                            apb.prdata[OVR_W-1:0] = r_ovr[i];
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            r_irq_d   <= '0;
            r_pending <= '0;
            r_enable  <= '0;
            r_fabint  <= 1'b0;
            // NOTE: the overrun array is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < NSRC; i++) r_ovr[i] <= '0;
        end else begin
            r_irq_d   <= irq_in;
            r_pending <= w_pending_next;
            r_enable  <= w_enable_next;
            r_fabint  <= |(w_pending_next & w_enable_next);
            for (int i = 0; i < NSRC; i++) begin
                if (w_wr && w_is_ovr && w_ovr_idx == 4'(i))
                    r_ovr[i] <= '0;
                else if (w_edge[i] && r_pending[i] && !w_clr[i] && r_ovr[i] != OVR_MAX)
                    r_ovr[i] <= r_ovr[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fabint_collector.sv
// Directed bench for fabint_collector: APB register access, edge capture, overrun and masking.
module tb_fabint_collector;

    localparam int NSRC  = 4;
    localparam int OVR_W = 2;

    logic            pclk;
    logic            nreset;
    logic [NSRC-1:0] irq_in;
    logic            fabint;

    fabint_collector_if bus ();

    fabint_collector #(.NSRC(NSRC), .OVR_W(OVR_W)) dut (
        .pclk   (pclk),
        .nreset (nreset),
        .irq_in (irq_in),
        .apb    (bus),
        .fabint (fabint)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] rd_data;
    logic        rd_err;
    logic        rd_rdy;
    logic        wr_err;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [NSRC-1:0] raise = '0);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = addr; bus.pwdata = data;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        irq_in = irq_in | raise;
        #1 wr_err = bus.pslverr;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = addr;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #1;
        rd_data = bus.prdata;
        rd_err  = bus.pslverr;
        rd_rdy  = bus.pready;
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic pulse(input int src);
        @(posedge pclk); #1 irq_in[src] = 1'b1;
        @(posedge pclk); #1 irq_in[src] = 1'b0;
        @(posedge pclk);
    endtask

    initial begin
        nreset = 1'b0; irq_in = '0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_fabint", {31'd0, fabint}, 32'd0);
        nreset = 1'b1;
        repeat (2) @(posedge pclk);
        #1 check("idle_prdata", bus.prdata, 32'd0);
        check("idle_pslverr", {31'd0, bus.pslverr}, 32'd0);

        // 1: idle state after reset
        apb_read(8'h00);
        check("t1_status", rd_data, 32'd0);
        check("t1_pready", {31'd0, rd_rdy}, 32'd1);
        check("t1_pslverr", {31'd0, rd_err}, 32'd0);
        for (int i = 0; i < NSRC; i++) begin
            apb_read(8'(8'h10 + 4 * i));
            check($sformatf("t1_ovr%0d", i), rd_data, 32'd0);
            check($sformatf("t1_pready%0d", i), {31'd0, rd_rdy}, 32'd1);
        end

        // 2: single pulse, enabled, then clear
        apb_write(8'h08, 32'h1);
        apb_read(8'h08);
        check("t2_enable", rd_data, 32'h1);
        @(posedge pclk); #1 irq_in[0] = 1'b1;
        @(posedge pclk); #1;
        check("t2_fabint_set", {31'd0, fabint}, 32'd1);
        irq_in[0] = 1'b0;
        apb_read(8'h00);
        check("t2_status", rd_data, 32'h1);
        apb_write(8'h04, 32'h1);
        check("t2_fabint_clr", {31'd0, fabint}, 32'd0);
        apb_read(8'h04);
        check("t2_clear_reads0", rd_data, 32'd0);
        apb_read(8'h00);
        check("t2_status_clr", rd_data, 32'd0);

        // 3: level held 20 cycles is one event; source masked
        @(posedge pclk); #1 irq_in[1] = 1'b1;
        repeat (20) @(posedge pclk);
        apb_read(8'h0C);
        check("t3_raw", rd_data, 32'h2);
        #1 irq_in[1] = 1'b0;
        check("t3_fabint_masked", {31'd0, fabint}, 32'd0);
        apb_read(8'h00);
        check("t3_status", rd_data, 32'h2);
        apb_read(8'h14);
        check("t3_ovr1", rd_data, 32'd0);

        // 4: overrun counting, write-to-clear, saturation at 3
        repeat (3) pulse(2);
        apb_read(8'h18);
        check("t4_ovr2", rd_data, 32'd2);
        apb_write(8'h18, 32'h5A);
        apb_read(8'h18);
        check("t4_ovr2_wclr", rd_data, 32'd0);
        repeat (5) pulse(2);
        apb_read(8'h18);
        check("t4_ovr2_sat", rd_data, 32'd3);
        apb_read(8'h00);
        check("t4_status", rd_data, 32'h6);

        // 5: edge on src3 coincident with its clear
        pulse(3);
        apb_write(8'h04, 32'h8, 4'h8);
        #1 irq_in[3] = 1'b0;
        apb_read(8'h00);
        check("t5_status", rd_data, 32'hE);
        apb_read(8'h1C);
        check("t5_ovr3", rd_data, 32'd0);

        // 6: unmapped access, write-ignored STATUS, masking and re-enable
        apb_read(8'h40);
        check("t6_err_rd", {31'd0, rd_err}, 32'd1);
        check("t6_err_prdata", rd_data, 32'd0);
        apb_write(8'h20, 32'hFFFF_FFFF);
        check("t6_err_wr_ovr4", {31'd0, wr_err}, 32'd1);
        apb_write(8'h00, 32'h0);
        check("t6_status_wr_noerr", {31'd0, wr_err}, 32'd0);
        apb_write(8'h04, 32'hA);
        apb_read(8'h00);
        check("t6_status", rd_data, 32'h4);
        apb_write(8'h08, 32'hFFFF_FFF4);
        check("t6_fabint_en", {31'd0, fabint}, 32'd1);
        apb_read(8'h08);
        check("t6_enable_trunc", rd_data, 32'h4);
        apb_write(8'h08, 32'h0);
        check("t6_fabint_dis", {31'd0, fabint}, 32'd0);
        apb_read(8'h00);
        check("t6_status_kept", rd_data, 32'h4);
        apb_write(8'h08, 32'h4);
        check("t6_fabint_reen", {31'd0, fabint}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
